// File: rtl/pad_responder.sv
// Device-side responder for a PlayStation-style controller link (guitar pad emulator).
// Build option: define PAD_ANALOG_EN to enable the 0x44 analog-mode command and analog_mode.
module pad_responder #(
  parameter int ACK_DELAY = 12,
  parameter int ACK_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        attention,
  input  logic        pad_clk,
  input  logic        command,
  input  logic [15:0] buttons,
  output logic        data,
  output logic        ack_n,
  output logic        config_mode,
  output logic        analog_mode,
  output logic        frame_done
);

  localparam int CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(ACK_DELAY);
  localparam logic [CNT_W-1:0] WIDTH_END = CNT_W'(ACK_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [7:0] CMD_POLL   = 8'h42;
  localparam logic [7:0] CMD_CONFIG = 8'h43;
`ifdef PAD_ANALOG_EN
  localparam logic [7:0] CMD_ANALOG = 8'h44;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_ACK_WAIT,
    S_ACK,
    S_DONE
  } state_t;

  // [0],[1] are the synchronizer stages, [2] is the edge-detect history
  logic [2:0] att_sync_q;
  logic [2:0] pclk_sync_q;
  logic [1:0] cmd_sync_q;

  state_t           state_q, state_d;
  logic [3:0]       byte_q, byte_d;
  logic [2:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      snap_q, snap_d;
  logic [6:0]       rx_q, rx_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             long_q, long_d;
  logic             data_q, data_d;
  logic             ack_n_q, ack_n_d;
  logic             cfg_q, cfg_d;
  logic             done_q, done_d;
  logic             ana_mode;

`ifdef PAD_ANALOG_EN
  logic             ana_q, ana_d;
  assign ana_mode = ana_q;
`else
  assign ana_mode = 1'b0;
`endif

  logic       att_rise, att_low, pclk_fall, pclk_rise, cmd_bit, last_byte;
  logic [7:0] rx_full;
  logic [7:0] tx_byte;

  assign att_rise  = att_sync_q[1] & ~att_sync_q[2];
  assign att_low   = ~att_sync_q[1];
  assign pclk_fall = ~pclk_sync_q[1] & pclk_sync_q[2];
  assign pclk_rise = pclk_sync_q[1] & ~pclk_sync_q[2];
  assign cmd_bit   = cmd_sync_q[1];
  // rx_q holds bits 0..6 of the byte in flight; the 8th bit arrives with the final rise
  assign rx_full   = {cmd_bit, rx_q};
  assign last_byte = (byte_q == (long_q ? 4'd8 : 4'd4));

  always_comb begin
    tx_byte = 8'hFF;
    case (byte_q)
      4'd0: tx_byte = 8'hFF;
      4'd1: tx_byte = cfg_q ? 8'hF3 : (ana_mode ? 8'h73 : 8'h41);
      4'd2: tx_byte = 8'h5A;
      default: begin
        if (cmd_q == CMD_POLL) begin
          if (byte_q == 4'd3) begin
            tx_byte = snap_q[7:0];
          end else if (byte_q == 4'd4) begin
            tx_byte = snap_q[15:8];
          end else begin
            tx_byte = 8'hFF;
          end
        end else begin
          tx_byte = 8'h00;
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    rx_d    = rx_q;
    cmd_d   = cmd_q;
    long_d  = long_q;
    data_d  = data_q;
    ack_n_d = ack_n_q;
    cfg_d   = cfg_q;
    done_d  = 1'b0;
`ifdef PAD_ANALOG_EN
    ana_d   = ana_q;
`endif
    if (state_q != S_IDLE && att_rise) begin
      // Host deselect ends the frame; it outranks any pad_clk edge seen in the same cycle.
      state_d = S_IDLE;
      data_d  = 1'b1;
      ack_n_d = 1'b1;
      done_d  = (state_q == S_DONE);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (att_low) begin
            snap_d  = ~buttons;
            byte_d  = 4'd0;
            bit_d   = 3'd0;
            cmd_d   = 8'h00;
            long_d  = cfg_q | ana_mode;
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (pclk_fall) begin
            data_d = tx_byte[bit_q];
          end else if (pclk_rise) begin
            rx_d  = {cmd_bit, rx_q[6:1]};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              cnt_d = '0;
              if (byte_q == 4'd1) begin
                cmd_d = rx_full;
              end
              if (byte_q == 4'd3) begin
                if (cmd_q == CMD_CONFIG) begin
                  if (rx_full == 8'h01) begin
                    cfg_d = 1'b1;
                  end else if (rx_full == 8'h00) begin
                    cfg_d = 1'b0;
                  end
                end
`ifdef PAD_ANALOG_EN
                if (cmd_q == CMD_ANALOG && cfg_q) begin
                  if (rx_full == 8'h01) begin
                    ana_d = 1'b1;
                  end else if (rx_full == 8'h00) begin
                    ana_d = 1'b0;
                  end
                end
`endif
              end
              if (last_byte) begin
                data_d  = 1'b1;
                state_d = S_DONE;
              end else begin
                state_d = S_ACK_WAIT;
              end
            end
          end
        end
        S_ACK_WAIT: begin
          if (cnt_q == DELAY_END) begin
            cnt_d   = '0;
            ack_n_d = 1'b0;
            state_d = S_ACK;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_ACK: begin
          if (cnt_q == WIDTH_END) begin
            ack_n_d = 1'b1;
            data_d  = 1'b1;
            byte_d  = byte_q + 4'd1;
            bit_d   = 3'd0;
            state_d = S_SHIFT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_DONE: begin
          data_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      att_sync_q  <= 3'b111;
      pclk_sync_q <= 3'b111;
      cmd_sync_q  <= 2'b11;
      state_q     <= S_IDLE;
      byte_q      <= 4'd0;
      bit_q       <= 3'd0;
      cnt_q       <= '0;
      snap_q      <= 16'hFFFF;
      rx_q        <= 7'd0;
      cmd_q       <= 8'h00;
      long_q      <= 1'b0;
      data_q      <= 1'b1;
      ack_n_q     <= 1'b1;
      cfg_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      att_sync_q  <= {att_sync_q[1:0], attention};
      pclk_sync_q <= {pclk_sync_q[1:0], pad_clk};
      cmd_sync_q  <= {cmd_sync_q[0], command};
      state_q     <= state_d;
      byte_q      <= byte_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      rx_q        <= rx_d;
      cmd_q       <= cmd_d;
      long_q      <= long_d;
      data_q      <= data_d;
      ack_n_q     <= ack_n_d;
      cfg_q       <= cfg_d;
      done_q      <= done_d;
    end
  end

`ifdef PAD_ANALOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ana_q <= 1'b0;
    end else begin
      ana_q <= ana_d;
    end
  end
`endif

  assign data        = data_q;
  assign ack_n       = ack_n_q;
  assign config_mode = cfg_q;
  assign analog_mode = ana_mode;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_pad_responder.sv
// Host-side bench for pad_responder: randomized frames checked against a reply/mode model.
`timescale 1ns/1ps
module tb_pad_responder;

  localparam int ACK_DELAY = 12;
  localparam int ACK_WIDTH = 8;
  localparam int HALF      = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        attention;
  logic        pad_clk;
  logic        command;
  logic [15:0] buttons;
  logic        data;
  logic        ack_n;
  logic        config_mode;
  logic        analog_mode;
  logic        frame_done;

  int vectors     = 0;
  int miscompares = 0;

  // model of the pad's modes as the host should believe them
  logic mdl_cfg;
  logic mdl_ana;

  pad_responder #(
    .ACK_DELAY(ACK_DELAY),
    .ACK_WIDTH(ACK_WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .attention  (attention),
    .pad_clk    (pad_clk),
    .command    (command),
    .buttons    (buttons),
    .data       (data),
    .ack_n      (ack_n),
    .config_mode(config_mode),
    .analog_mode(analog_mode),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic int model_len();
    return (mdl_cfg || mdl_ana) ? 9 : 5;
  endfunction

  function automatic logic [7:0] model_reply(input int idx, input logic [7:0] cmd,
                                             input logic [15:0] btn);
    logic [15:0] snap;
    snap = ~btn;
    if (idx == 0) return 8'hFF;
    if (idx == 1) return mdl_cfg ? 8'hF3 : (mdl_ana ? 8'h73 : 8'h41);
    if (idx == 2) return 8'h5A;
    if (cmd != 8'h42) return 8'h00;
    if (idx == 3) return snap[7:0];
    if (idx == 4) return snap[15:8];
    return 8'hFF;
  endfunction

  function automatic void model_commit(input logic [7:0] cmd, input logic [7:0] arg);
    if (cmd == 8'h43 && arg == 8'h01) mdl_cfg = 1'b1;
    else if (cmd == 8'h43 && arg == 8'h00) mdl_cfg = 1'b0;
`ifdef PAD_ANALOG_EN
    else if (cmd == 8'h44 && mdl_cfg && arg == 8'h01) mdl_ana = 1'b1;
    else if (cmd == 8'h44 && mdl_cfg && arg == 8'h00) mdl_ana = 1'b0;
`endif
  endfunction

  // Shifts one byte; returns at the negedge where the 8th rising edge was driven.
  task automatic host_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pad_clk = 1'b0;
      command = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i]   = data;
      pad_clk = 1'b1;
      if (i != 7) repeat (HALF - 1) @(negedge clk);
    end
  endtask

  task automatic wait_ack(input string name);
    int n;
    int w;
    n = 0;
    @(negedge clk);
    n = 1;
    while (ack_n !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n != ACK_DELAY + 4) begin
      miscompares++;
      $display("FAIL %s ack_delay: got %0d cycles, expected %0d", name, n, ACK_DELAY + 4);
    end
    w = 0;
    while (ack_n === 1'b0 && w < 100) begin
      w++;
      @(negedge clk);
    end
    vectors++;
    if (w != ACK_WIDTH) begin
      miscompares++;
      $display("FAIL %s ack_width: got %0d cycles, expected %0d", name, w, ACK_WIDTH);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] arg,
                           input logic [15:0] btn, input string name);
    logic [7:0] host_tx [9];
    logic [7:0] exp_rx  [9];
    logic [7:0] got;
    int len;
    int bad_ack;
    int pulses;
    len = model_len();
    host_tx[0] = 8'h01;
    host_tx[1] = cmd;
    host_tx[2] = 8'h00;
    host_tx[3] = arg;
    for (int i = 4; i < 9; i++) host_tx[i] = 8'($urandom);
    for (int i = 0; i < 9; i++) exp_rx[i] = model_reply(i, cmd, btn);
    @(negedge clk);
    buttons   = btn;
    attention = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int b = 0; b < len; b++) begin
      host_byte(host_tx[b], got);
      if (b == 0) buttons = 16'($urandom);
      vectors++;
      if (got !== exp_rx[b]) begin
        miscompares++;
        $display("FAIL %s byte%0d: got %h, expected %h", name, b, got, exp_rx[b]);
      end
      if (b < len - 1) wait_ack(name);
    end
    bad_ack = 0;
    repeat (ACK_DELAY + 10) begin
      @(negedge clk);
      if (ack_n !== 1'b1) bad_ack++;
    end
    vectors++;
    if (bad_ack != 0) begin
      miscompares++;
      $display("FAIL %s ack_after_last: ack_n low %0d cycles, expected 0", name, bad_ack);
    end
    attention = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (frame_done === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL %s frame_done: got %0d pulses, expected 1", name, pulses);
    end
    model_commit(cmd, arg);
    vectors++;
    if (config_mode !== mdl_cfg || analog_mode !== mdl_ana) begin
      miscompares++;
      $display("FAIL %s modes: got cfg=%b ana=%b, expected cfg=%b ana=%b",
               name, config_mode, analog_mode, mdl_cfg, mdl_ana);
    end
    $display("frame %s cmd=%h arg=%h len=%0d cfg=%b ana=%b", name, cmd, arg, len,
             config_mode, analog_mode);
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    attention = 1'b1;
    pad_clk   = 1'b1;
    command   = 1'b1;
    buttons   = 16'h0000;
    mdl_cfg   = 1'b0;
    mdl_ana   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({data, ack_n, config_mode, analog_mode, frame_done} !== 5'b11000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, expected 11000",
               {data, ack_n, config_mode, analog_mode, frame_done});
    end
    $display("reset outputs data=%b ack_n=%b cfg=%b ana=%b done=%b",
             data, ack_n, config_mode, analog_mode, frame_done);
  endtask

  task automatic test_poll_digital();
    run_frame(8'h42, 8'h00, 16'h0201, "poll_digital");
  endtask

  task automatic test_config();
    run_frame(8'h43, 8'h01, 16'($urandom), "enter_config");
    run_frame(8'h42, 8'h00, 16'($urandom), "poll_config");
  endtask

  task automatic test_analog_mode();
    run_frame(8'h44, 8'h01, 16'($urandom), "analog_on");
    run_frame(8'h43, 8'h00, 16'($urandom), "exit_config");
    run_frame(8'h42, 8'h00, 16'($urandom), "poll_after_analog");
    run_frame(8'h43, 8'h01, 16'($urandom), "reenter_config");
    run_frame(8'h44, 8'h00, 16'($urandom), "analog_off");
    run_frame(8'h43, 8'h00, 16'($urandom), "exit_config2");
  endtask

  task automatic test_abort();
    logic [7:0] got;
    logic [7:0] exp_id;
    int n;
    int pulses;
    int bad;
    exp_id = model_reply(1, 8'h42, 16'h0000);
    // abort while ack_n is low after byte 1
    @(negedge clk);
    buttons   = 16'($urandom);
    attention = 1'b0;
    repeat (HALF) @(negedge clk);
    host_byte(8'h01, got);
    vectors++;
    if (got !== 8'hFF) begin
      miscompares++;
      $display("FAIL abort_byte0: got %h, expected ff", got);
    end
    wait_ack("abort");
    host_byte(8'h42, got);
    vectors++;
    if (got !== exp_id) begin
      miscompares++;
      $display("FAIL abort_id: got %h, expected %h", got, exp_id);
    end
    n = 0;
    while (ack_n !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    attention = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (ack_n !== 1'b1 || data !== 1'b1 || n >= 100) begin
      miscompares++;
      $display("FAIL abort_in_ack: got ack_n=%b data=%b wait=%0d, expected 1 1 <100",
               ack_n, data, n);
    end
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (frame_done === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL abort_frame_done: got %0d pulses, expected 0", pulses);
    end
    $display("abort during ack: ack_n=%b data=%b done_pulses=%0d", ack_n, data, pulses);
    // abort mid-byte while data is driving a 0 (bit 0 of 0x5A)
    attention = 1'b0;
    repeat (HALF) @(negedge clk);
    host_byte(8'h01, got);
    wait_ack("abort2");
    host_byte(8'h42, got);
    wait_ack("abort2");
    @(negedge clk);
    pad_clk = 1'b0;
    command = 1'b0;
    repeat (HALF) @(negedge clk);
    vectors++;
    if (data !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_midbyte_bit: got %b, expected 0", data);
    end
    attention = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (data !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_midbyte_data: got %b, expected 1", data);
    end
    pad_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    // abort and pad_clk fall in the same cycle: the abort must win
    attention = 1'b0;
    repeat (HALF) @(negedge clk);
    host_byte(8'h01, got);
    wait_ack("abort3");
    host_byte(8'h42, got);
    wait_ack("abort3");
    @(negedge clk);
    pad_clk   = 1'b0;
    attention = 1'b1;
    bad = 0;
    repeat (HALF * 2) begin
      @(negedge clk);
      if (data !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL abort_vs_fall: data low %0d cycles, expected 0", bad);
    end
    pad_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    run_frame(8'h42, 8'h00, 16'($urandom), "after_abort");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got;
    int n;
    run_frame(8'h43, 8'h01, 16'($urandom), "config_for_reset");
    @(negedge clk);
    attention = 1'b0;
    repeat (HALF) @(negedge clk);
    host_byte(8'h01, got);
    wait_ack("reset_mid");
    host_byte(8'h42, got);
    wait_ack("reset_mid");
    host_byte(8'h00, got);
    vectors++;
    if (got !== 8'h5A) begin
      miscompares++;
      $display("FAIL reset_mid_byte2: got %h, expected 5a", got);
    end
    n = 0;
    while (ack_n !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (ack_n !== 1'b1 || config_mode !== 1'b0 || data !== 1'b1 || n >= 100) begin
      miscompares++;
      $display("FAIL reset_mid_frame: got ack_n=%b cfg=%b data=%b wait=%0d, expected 1 0 1 <100",
               ack_n, config_mode, data, n);
    end
    $display("reset mid-frame: ack_n=%b cfg=%b data=%b", ack_n, config_mode, data);
    mdl_cfg = 1'b0;
    mdl_ana = 1'b0;
    @(negedge clk);
    attention = 1'b1;
    pad_clk   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (HALF) @(negedge clk);
    run_frame(8'h42, 8'h00, 16'($urandom), "poll_after_reset");
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    logic [7:0] arg;
    for (int i = 0; i < 22; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    cmd = 8'h42;
        2:       cmd = 8'h43;
        3:       cmd = 8'h44;
        4:       cmd = 8'h45;
        default: cmd = 8'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0:       arg = 8'h00;
        1:       arg = 8'h01;
        default: arg = 8'($urandom);
      endcase
      run_frame(cmd, arg, 16'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_poll_digital();
    test_config();
    test_analog_mode();
    test_abort();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
